// File: rtl/qoi_stream_framer.sv
// -----------------------------------------------------------------------------
// qoi_stream_framer
//
// Wraps the raw chunk byte stream from the QOI encoder core into a complete
// QOI file: a 14-byte header ("qoif", width, height, channels, colorspace),
// the payload passed through unchanged, then the 8-byte end marker
// (seven 0x00 bytes followed by 0x01). The output is a registered byte
// stream with a valid/ready handshake that sustains one byte per clock.
//
// Ports
//   clk          single clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse, honoured only while idle
//   img_width    image width in pixels, sampled when start is accepted
//   img_height   image height in pixels, sampled when start is accepted
//   enc_data     encoded chunk byte from the encoder
//   enc_valid    enc_data is valid
//   enc_last     enc_data is the final payload byte (only with enc_valid)
//   enc_ready    framer takes the encoder byte this cycle
//   out_data     framed output byte (registered)
//   out_valid    out_data is valid (registered)
//   out_ready    sink accepts the output byte
//   busy         high whenever a frame is in progress
//   done         one-cycle pulse after the final marker byte is accepted
//   byte_count   output bytes accepted in the current frame (saturating)
// -----------------------------------------------------------------------------
module qoi_stream_framer #(
    parameter int CHANNELS   = 4,  // header byte 12: 3 = RGB, 4 = RGBA
    parameter int COLORSPACE = 0   // header byte 13: 0 = sRGB, 1 = linear
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] img_width,
    input  logic [31:0] img_height,
    input  logic [7:0]  enc_data,
    input  logic        enc_valid,
    input  logic        enc_last,
    output logic        enc_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] byte_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_TAIL,
        ST_FIN
    } state_t;

    localparam logic [7:0] CHANNELS_BYTE   = CHANNELS[7:0];
    localparam logic [7:0] COLORSPACE_BYTE = COLORSPACE[7:0];
    localparam logic [3:0] HDR_LAST_IDX    = 4'd13;
    localparam logic [3:0] TAIL_LAST_IDX   = 4'd7;

    state_t      state;
    state_t      state_nx;

    logic [31:0] width_q;
    logic [31:0] height_q;
    logic [3:0]  idx;          // byte position within the header or tail

    logic        out_free;     // output register may load this cycle
    logic        out_xfer;     // sink takes the current output byte
    logic        no_payload;   // latched frame has a zero dimension

    // Control strobes from the next-state logic to the datapath.
    logic        accept_start;
    logic        load_byte;
    logic [7:0]  load_value;
    logic        idx_inc;
    logic        idx_clr;
    logic        fin_xfer;

    logic [7:0]  hdr_byte;

    assign out_free   = !out_valid || out_ready;
    assign out_xfer   = out_valid && out_ready;
    assign no_payload = (width_q == 32'd0) || (height_q == 32'd0);
    assign busy       = (state != ST_IDLE);

    // Header byte selected by the index: magic, big-endian width and
    // height, then the two format bytes.
    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            4'd0:    hdr_byte = 8'h71;
            4'd1:    hdr_byte = 8'h6F;
            4'd2:    hdr_byte = 8'h69;
            4'd3:    hdr_byte = 8'h66;
            4'd4:    hdr_byte = width_q[31:24];
            4'd5:    hdr_byte = width_q[23:16];
            4'd6:    hdr_byte = width_q[15:8];
            4'd7:    hdr_byte = width_q[7:0];
            4'd8:    hdr_byte = height_q[31:24];
            4'd9:    hdr_byte = height_q[23:16];
            4'd10:   hdr_byte = height_q[15:8];
            4'd11:   hdr_byte = height_q[7:0];
            4'd12:   hdr_byte = CHANNELS_BYTE;
            4'd13:   hdr_byte = COLORSPACE_BYTE;
            default: hdr_byte = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before the case so no
        // path through the block leaves it unassigned and infers a latch.
        state_nx     = state;
        enc_ready    = 1'b0;
        accept_start = 1'b0;
        load_byte    = 1'b0;
        load_value   = 8'h00;
        idx_inc      = 1'b0;
        idx_clr      = 1'b0;
        fin_xfer     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nx     = ST_HDR;
                end
            end

            ST_HDR: begin
                if (out_free) begin
                    load_byte  = 1'b1;
                    load_value = hdr_byte;
                    if (idx == HDR_LAST_IDX) begin
                        idx_clr  = 1'b1;
                        state_nx = no_payload ? ST_TAIL : ST_BODY;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            ST_BODY: begin
                // The encoder is only ready when the output register can take
                // its byte on the same edge, so nothing needs buffering here.
                enc_ready = out_free;
                if (enc_valid && out_free) begin
                    load_byte  = 1'b1;
                    load_value = enc_data;
                    if (enc_last) begin
                        idx_clr  = 1'b1;
                        state_nx = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                if (out_free) begin
                    load_byte  = 1'b1;
                    load_value = (idx == TAIL_LAST_IDX) ? 8'h01 : 8'h00;
                    if (idx == TAIL_LAST_IDX) begin
                        idx_clr  = 1'b1;
                        state_nx = ST_FIN;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            ST_FIN: begin
                // The closing 0x01 sits in the output register; the frame is
                // complete once the sink takes it.
                if (out_xfer) begin
                    fin_xfer = 1'b1;
                    state_nx = ST_IDLE;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (load_byte) begin
            out_valid <= 1'b1;
            out_data  <= load_value;
        end else if (out_xfer) begin
            // Byte consumed with nothing new to load; out_data keeps its value
            // but is no longer qualified.
            out_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Frame bookkeeping: latched geometry, index, status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q  <= 32'd0;
            height_q <= 32'd0;
        end else if (accept_start) begin
            width_q  <= img_width;
            height_q <= img_height;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= 4'd0;
        end else if (accept_start || idx_clr) begin
            idx <= 4'd0;
        end else if (idx_inc) begin
            idx <= idx + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= 32'd0;
        end else if (accept_start) begin
            byte_count <= 32'd0;
        end else if (out_xfer && (byte_count != 32'hFFFF_FFFF)) begin
            byte_count <= byte_count + 32'd1;
        end
    end

    // done rises on the same edge that returns the state to IDLE, so busy
    // and done never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= fin_xfer;
        end
    end

endmodule

// File: tb/tb_qoi_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_qoi_stream_framer
//
// Drives qoi_stream_framer with directed and randomized frames and compares
// the accepted output stream with a file image assembled from the QOI layout
// rules (magic, big-endian geometry, format bytes, payload, end marker).
// -----------------------------------------------------------------------------
module tb_qoi_stream_framer;

    localparam int          BUDGET     = 3000;
    localparam logic [7:0]  CHANNELS   = 8'd4;
    localparam logic [7:0]  COLORSPACE = 8'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] img_width = 32'd0;
    logic [31:0] img_height = 32'd0;
    logic [7:0]  enc_data = 8'h00;
    logic        enc_valid = 1'b0;
    logic        enc_last = 1'b0;
    logic        enc_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    qoi_stream_framer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .enc_data   (enc_data),
        .enc_valid  (enc_valid),
        .enc_last   (enc_last),
        .enc_ready  (enc_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    int         tests = 0;
    int         fails = 0;

    logic [7:0] out_q[$];   // bytes the sink accepted
    logic [7:0] exp_q[$];   // expected file image
    logic [7:0] pay_q[$];   // payload the encoder model offers

    int         stall_err;
    int         rdy_err;
    int         enc_ready_seen;
    bit         mon_prev_stall = 1'b0;
    logic [7:0] mon_prev_data = 8'h00;

    // Monitor: samples mid-cycle, between edges.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_stall = 1'b0;
            end else begin
                if (mon_prev_stall && (!out_valid || out_data !== mon_prev_data))
                    stall_err++;
                if (enc_ready && out_valid && !out_ready)
                    rdy_err++;
                if (enc_ready)
                    enc_ready_seen++;
                if (out_valid && out_ready)
                    out_q.push_back(out_data);
                mon_prev_stall = out_valid && !out_ready;
                mon_prev_data  = out_data;
            end
        end
    end

    // Expected file image for geometry w x h carrying pay_q.
    task automatic build_expected(input logic [31:0] w, input logic [31:0] h);
        string magic;
        magic = "qoif";
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(magic[i]));
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((h >> (8 * i)) & 32'hFF));
        exp_q.push_back(CHANNELS);
        exp_q.push_back(COLORSPACE);
        if (w != 0 && h != 0)
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
    endtask

    // Runs one frame from the current point (just after a rising edge).
    // ready_mode: 0 always ready, 1 alternating 1010, 2 random.
    // valid_mode: 0 encoder always valid while data remains, 1 random.
    // glitch_cyc: cycle at which start is re-pulsed with width 0x1234.
    // end_len:    if > 0, start is raised in the final-transfer cycle.
    task automatic run_frame(input logic [31:0] w, input logic [31:0] h,
                             input int ready_mode, input int valid_mode,
                             input int glitch_cyc, input int end_len,
                             output bit busy_seen, output bit timed_out);
        int  pi;
        int  cyc;
        int  n;
        bit  took;
        n = pay_q.size();
        out_q.delete();
        stall_err      = 0;
        rdy_err        = 0;
        enc_ready_seen = 0;
        timed_out      = 1'b0;
        pi             = 0;
        cyc            = 0;
        img_width      = w;
        img_height     = h;
        start          = 1'b1;
        out_ready      = 1'b1;
        enc_valid      = 1'b0;
        enc_last       = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_seen = busy;
        forever begin
            start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) img_width = 32'h0000_1234;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (pi < n && (valid_mode == 0 || $urandom_range(0, 1) == 1)) begin
                enc_valid = 1'b1;
                enc_data  = pay_q[pi];
                enc_last  = (pi == n - 1);
            end else begin
                enc_valid = 1'b0;
                enc_data  = 8'($urandom);
                enc_last  = (valid_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (end_len > 0 && out_valid && out_ready && out_q.size() == end_len - 1)
                start = 1'b1;
            @(negedge clk);
            took = enc_valid && enc_ready;
            @(posedge clk); #1;
            if (took) pi++;
            if (done) break;
            cyc++;
            if (cyc > BUDGET) begin
                timed_out = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        enc_valid = 1'b0;
        enc_last  = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests++;
        if (out_data !== 8'h00) begin
            fails++; $display("FAIL reset_out_data: got %h want 00", out_data);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || enc_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: busy=%b done=%b enc_ready=%b want 0 0 0",
                     busy, done, enc_ready);
        end
        tests++;
        if (byte_count !== 32'd0) begin
            fails++; $display("FAIL reset_byte_count: got %0d want 0", byte_count);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL idle_no_start: busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_header_and_payload();
        logic [7:0] hdr_lit [14] = '{8'h71, 8'h6F, 8'h69, 8'h66, 8'h00, 8'h00, 8'h00,
                                     8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h00};
        bit bs, to;
        int mism;
        pay_q = '{8'hFE, 8'h10, 8'h20, 8'h30};
        run_frame(32'd2, 32'd1, 0, 0, -1, 0, bs, to);
        tests++;
        if (to) begin fails++; $display("FAIL hdr_timeout: no done within %0d cycles", BUDGET); end
        tests++;
        if (bs !== 1'b1) begin fails++; $display("FAIL hdr_busy: got %b want 1", bs); end
        mism = -1;
        for (int i = 0; i < 14; i++)
            if (mism < 0 && (i >= out_q.size() || out_q[i] !== hdr_lit[i])) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL hdr_bytes: byte %0d got %h want %h", mism,
                     (mism < out_q.size()) ? out_q[mism] : 8'hxx, hdr_lit[mism]);
        end
        tests++;
        if (out_q.size() != 26) begin
            fails++; $display("FAIL frame_len: got %0d want 26", out_q.size());
        end
        mism = -1;
        for (int i = 14; i < 26; i++) begin
            logic [7:0] want;
            if (i < 18)       want = pay_q[i - 14];
            else if (i == 25) want = 8'h01;
            else              want = 8'h00;
            if (mism < 0 && (i >= out_q.size() || out_q[i] !== want)) mism = i;
        end
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL payload_tail: mismatch at byte %0d got %h", mism,
                     (mism < out_q.size()) ? out_q[mism] : 8'hxx);
        end
        tests++;
        if (byte_count !== 32'd26) begin
            fails++; $display("FAIL hdr_byte_count: got %0d want 26", byte_count);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL done_pulse: done=%b busy=%b want 0 0 one cycle later", done, busy);
        end
    endtask

    task automatic test_backpressure();
        bit bs, to;
        int mism;
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'($urandom));
        build_expected(32'd640, 32'd480);
        run_frame(32'd640, 32'd480, 1, 0, -1, 0, bs, to);
        tests++;
        if (to) begin fails++; $display("FAIL bp_timeout: no done within %0d cycles", BUDGET); end
        tests++;
        if (stall_err != 0 || rdy_err != 0) begin
            fails++;
            $display("FAIL bp_stall: unstable stalls %0d, enc_ready during stall %0d, want 0 0",
                     stall_err, rdy_err);
        end
        mism = (out_q.size() == exp_q.size()) ? -1 : 9999;
        foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL bp_frame: len %0d want %0d, first bad byte %0d", out_q.size(), exp_q.size(), mism);
        end
    endtask

    task automatic test_zero_dim(input logic [31:0] w, input logic [31:0] h);
        bit bs, to;
        int mism;
        pay_q.delete();
        build_expected(w, h);
        run_frame(w, h, 0, 0, -1, 0, bs, to);
        tests++;
        if (to) begin fails++; $display("FAIL zero_timeout: no done within %0d cycles", BUDGET); end
        tests++;
        if (enc_ready_seen != 0) begin
            fails++; $display("FAIL zero_enc_ready: asserted %0d cycles want 0", enc_ready_seen);
        end
        mism = (out_q.size() == exp_q.size()) ? -1 : 9999;
        foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL zero_frame: len %0d want %0d, first bad byte %0d", out_q.size(), exp_q.size(), mism);
        end
        tests++;
        if (byte_count !== 32'd22) begin
            fails++; $display("FAIL zero_byte_count: got %0d want 22", byte_count);
        end
    endtask

    task automatic test_start_while_busy();
        bit bs, to;
        int mism;
        pay_q.delete();
        for (int i = 0; i < 40; i++) pay_q.push_back(8'($urandom));
        build_expected(32'd77, 32'd5);
        run_frame(32'd77, 32'd5, 0, 0, 20, 0, bs, to);
        tests++;
        if (to) begin fails++; $display("FAIL busy_start_timeout: no done within %0d cycles", BUDGET); end
        mism = (out_q.size() == exp_q.size()) ? -1 : 9999;
        foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL busy_start_frame: len %0d want %0d, first bad byte %0d",
                     out_q.size(), exp_q.size(), mism);
        end
        tests++;
        if (byte_count !== 32'(exp_q.size())) begin
            fails++; $display("FAIL busy_start_count: got %0d want %0d", byte_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hdr();
        bit bs, to;
        int cyc;
        int mism;
        out_q.delete();
        img_width  = 32'hDEAD_BEEF;
        img_height = 32'd9;
        out_ready  = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (out_q.size() < 6 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (out_q.size() < 6) begin
            fails++; $display("FAIL rst_hdr_progress: got %0d bytes want 6", out_q.size());
        end
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_hdr: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        pay_q = '{8'hAA, 8'h55};
        build_expected(32'd3, 32'd4);
        run_frame(32'd3, 32'd4, 0, 0, -1, 0, bs, to);
        tests++;
        if (out_q.size() == 0 || out_q[0] !== 8'h71) begin
            fails++; $display("FAIL rst_restart_first: got %h want 71",
                              (out_q.size() != 0) ? out_q[0] : 8'hxx);
        end
        mism = (out_q.size() == exp_q.size() && !to) ? -1 : 9999;
        foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL rst_restart_frame: len %0d want %0d, first bad byte %0d",
                     out_q.size(), exp_q.size(), mism);
        end
    endtask

    task automatic test_back_to_back();
        bit bs, to;
        int mism;
        pay_q = '{8'h01, 8'h02, 8'h03};
        build_expected(32'd1, 32'd3);
        run_frame(32'd1, 32'd3, 0, 0, -1, exp_q.size(), bs, to);
        tests++;
        if (to || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_start_at_return: busy=%b timeout=%b want 0 0", busy, to);
        end
        pay_q = '{8'h99};
        build_expected(32'd8, 32'd8);
        run_frame(32'd8, 32'd8, 2, 1, -1, 0, bs, to);
        tests++;
        if (bs !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b want 1", bs); end
        mism = (out_q.size() == exp_q.size() && !to) ? -1 : 9999;
        foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
        tests++;
        if (mism >= 0) begin
            fails++;
            $display("FAIL b2b_frame: len %0d want %0d, first bad byte %0d", out_q.size(), exp_q.size(), mism);
        end
    endtask

    task automatic test_random();
        bit bs, to;
        int mism;
        logic [31:0] w, h;
        for (int f = 0; f < 8; f++) begin
            w = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            h = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            pay_q.delete();
            if (w != 0 && h != 0)
                for (int i = 0; i < int'($urandom_range(1, 30)); i++) pay_q.push_back(8'($urandom));
            build_expected(w, h);
            run_frame(w, h, 2, 1, -1, 0, bs, to);
            mism = (out_q.size() == exp_q.size() && !to) ? -1 : 9999;
            foreach (exp_q[i]) if (mism < 0 && out_q[i] !== exp_q[i]) mism = i;
            tests++;
            if (mism >= 0 || stall_err != 0 || rdy_err != 0) begin
                fails++;
                $display("FAIL rand_frame_%0d: len %0d want %0d, bad byte %0d, stall %0d, rdy %0d",
                         f, out_q.size(), exp_q.size(), mism, stall_err, rdy_err);
            end
            tests++;
            if (byte_count !== 32'(exp_q.size())) begin
                fails++; $display("FAIL rand_count_%0d: got %0d want %0d", f, byte_count, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_header_and_payload();
        test_backpressure();
        test_zero_dim(32'd0, 32'd10);
        test_zero_dim(32'd10, 32'd0);
        test_start_while_busy();
        test_reset_mid_hdr();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
